rsa_modexp_core: RTL and testbench

- Parametrised RSA modular-exponentiation engine: result = plain^exponent mod modulus.
- Uses radix-2 bit-serial Montgomery multiplication.
- Replaces the tied-off encrypt_data / encrypt_status path behind the byte-peripheral register file, which drives its start/stop/operand inputs.
- Generalises the 8-bit register view to any operand width and adds abort, error and busy reporting.

---
 rtl/rsa_pkg.sv | 24 ++
 rtl/rsa_mont_mul.sv | 74 +++++++
 rtl/rsa_modexp_core.sv | 151 +++++++++++++++
 tb/tb_rsa_modexp_core.sv | 195 +++++++++++++++++++
 4 files changed

// File: rtl/rsa_pkg.sv
// Shared definitions for the RSA modular-exponentiation core: FSM states,
// default operand widths and status-register bit positions.
`timescale 1ns/1ps
package rsa_pkg;

    localparam int DEF_WIDTH     = 8;
    localparam int DEF_EXP_WIDTH = 8;

    // Bit positions of the status byte seen through the register file.
    localparam int STAT_DONE_BIT  = 0;
    localparam int STAT_ERROR_BIT = 1;
    localparam int STAT_BUSY_BIT  = 2;

    typedef enum logic [2:0] {
        IDLE,
        TO_MONT,
        INIT_ACC,
        SQUARE,
        MULT,
        FROM_MONT,
        DONE
    } state_t;

endpackage

// File: rtl/rsa_mont_mul.sv
// Radix-2 bit-serial Montgomery multiplier: p = a*b*R^-1 mod n, R = 2^WIDTH.
// One operand bit per cycle, final conditional subtract in the done cycle.
`timescale 1ns/1ps
module rsa_mont_mul
    import rsa_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clear,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [WIDTH-1:0] n,
    output logic             done,
    output logic [WIDTH-1:0] p
);

    localparam int CW = $clog2(WIDTH + 1);

    logic [WIDTH+1:0] r_s;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic [WIDTH-1:0] r_n;
    logic [CW-1:0]    r_cnt;
    logic             r_run;
    logic             r_done;

    logic [WIDTH+1:0] w_sum_b;
    logic [WIDTH+1:0] w_sum_n;
    logic [WIDTH-1:0] w_sub;

    // Two extra accumulator bits hold S + b + n without overflow while S < 2n.
    assign w_sum_b = r_s + ({(WIDTH+2){r_a[0]}} & {2'b00, r_b});
    assign w_sum_n = w_sum_b + ({(WIDTH+2){w_sum_b[0]}} & {2'b00, r_n});
    assign w_sub   = r_s[WIDTH-1:0] - r_n;

    assign p    = (r_s >= {2'b00, r_n}) ? w_sub : r_s[WIDTH-1:0];
    assign done = r_done;

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (!rst_n || clear) begin
            r_s    <= '0;
            r_a    <= '0;
            r_b    <= '0;
            r_n    <= '0;
            r_cnt  <= '0;
            r_run  <= 1'b0;
            r_done <= 1'b0;
        end else begin
            r_done <= 1'b0;
            if (start) begin
                r_s   <= '0;
                r_a   <= a;
                r_b   <= b;
                r_n   <= n;
                r_cnt <= '0;
                r_run <= 1'b1;
            end else if (r_run) begin
                r_s   <= w_sum_n >> 1;
                r_a   <= r_a >> 1;
                r_cnt <= r_cnt + CW'(1);
                if (r_cnt == CW'(WIDTH - 1)) begin
                    r_run  <= 1'b0;
                    r_done <= 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/rsa_modexp_core.sv
// RSA modular exponentiation (plain^exponent mod modulus) by left-to-right
// square-and-multiply in the Montgomery domain, with abort and error reporting.
`timescale 1ns/1ps
module rsa_modexp_core
    import rsa_pkg::*;
#(
    parameter int WIDTH     = DEF_WIDTH,
    parameter int EXP_WIDTH = DEF_EXP_WIDTH
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic                 stop,
    input  logic [WIDTH-1:0]     plain,
    input  logic [EXP_WIDTH-1:0] exponent,
    input  logic [WIDTH-1:0]     modulus,
    input  logic [WIDTH-1:0]     r2,
    output logic [WIDTH-1:0]     result,
    output logic                 busy,
    output logic                 done,
    output logic                 error
);

    localparam int KW = (EXP_WIDTH > 1) ? $clog2(EXP_WIDTH) : 1;

    state_t               r_state;
    logic [WIDTH-1:0]     r_plain;
    logic [EXP_WIDTH-1:0] r_exp;
    logic [WIDTH-1:0]     r_n;
    logic [WIDTH-1:0]     r_r2;
    logic [WIDTH-1:0]     r_xm;
    logic [WIDTH-1:0]     r_acc;
    logic [KW-1:0]        r_k;
    logic                 r_mm_start;
    logic [WIDTH-1:0]     r_result;
    logic                 r_busy;
    logic                 r_done;
    logic                 r_error;

    logic [WIDTH-1:0]     w_mm_a;
    logic [WIDTH-1:0]     w_mm_b;
    logic                 w_mm_done;
    logic [WIDTH-1:0]     w_mm_p;

    // NOTE: defaults before the case keep this purely combinational (no latch).
    always_comb begin
        w_mm_a = r_acc;
        w_mm_b = r_acc;
        case (r_state)
            TO_MONT:   begin w_mm_a = r_plain;    w_mm_b = r_r2;       end
            INIT_ACC:  begin w_mm_a = WIDTH'(1);  w_mm_b = r_r2;       end
            MULT:      begin                      w_mm_b = r_xm;       end
            FROM_MONT: begin                      w_mm_b = WIDTH'(1);  end
            default:   ;
        endcase
    end

    rsa_mont_mul #(.WIDTH(WIDTH)) u_mm (
        .clk   (clk),
        .rst_n (rst_n),
        .clear (stop),
        .start (r_mm_start),
        .a     (w_mm_a),
        .b     (w_mm_b),
        .n     (r_n),
        .done  (w_mm_done),
        .p     (w_mm_p)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state    <= IDLE;
            r_plain    <= '0;
            r_exp      <= '0;
            r_n        <= '0;
            r_r2       <= '0;
            r_xm       <= '0;
            r_acc      <= '0;
            r_k        <= '0;
            r_mm_start <= 1'b0;
            r_result   <= '0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_error    <= 1'b0;
        end else begin
            r_mm_start <= 1'b0;
            if (stop) begin
                r_state <= IDLE;
                r_busy  <= 1'b0;
            end else begin
                case (r_state)
                    IDLE: if (start) begin
                        if (!modulus[0]) begin
                            r_done   <= 1'b1;
                            r_error  <= 1'b1;
                            r_result <= '0;
                        end else begin
                            r_done     <= 1'b0;
                            r_error    <= 1'b0;
                            r_plain    <= plain;
                            r_exp      <= exponent;
                            r_n        <= modulus;
                            r_r2       <= r2;
                            r_busy     <= 1'b1;
                            r_mm_start <= 1'b1;
                            r_state    <= TO_MONT;
                        end
                    end
                    TO_MONT: if (w_mm_done) begin
                        r_xm       <= w_mm_p;
                        r_mm_start <= 1'b1;
                        r_state    <= INIT_ACC;
                    end
                    INIT_ACC: if (w_mm_done) begin
                        r_acc      <= w_mm_p;
                        r_k        <= KW'(EXP_WIDTH - 1);
                        r_mm_start <= 1'b1;
                        r_state    <= SQUARE;
                    end
                    // The NEXT decision is folded into the done cycle of SQUARE/MULT.
                    SQUARE, MULT: if (w_mm_done) begin
                        r_acc      <= w_mm_p;
                        r_mm_start <= 1'b1;
                        if (r_state == SQUARE && r_exp[r_k]) begin
                            r_state <= MULT;
                        end else if (r_k == '0) begin
                            r_state <= FROM_MONT;
                        end else begin
                            r_k     <= r_k - KW'(1);
                            r_state <= SQUARE;
                        end
                    end
                    FROM_MONT: if (w_mm_done) begin
                        r_result <= w_mm_p;
                        r_done   <= 1'b1;
                        r_busy   <= 1'b0;
                        r_state  <= DONE;
                    end
                    DONE:    r_state <= IDLE;
                    default: r_state <= IDLE;
                endcase
            end
        end
    end

    assign result = r_result;
    assign busy   = r_busy;
    assign done   = r_done;
    assign error  = r_error;

endmodule

// File: tb/tb_rsa_modexp_core.sv
// Directed self-checking bench for rsa_modexp_core with n = 187 = 11*17,
// R = 256, r2 = 256^2 mod 187 = 86; latencies follow 1 + N_mm*(WIDTH+2).
`timescale 1ns/1ps
module tb_rsa_modexp_core;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       start;
    logic       stop;
    logic [7:0] plain;
    logic [7:0] exponent;
    logic [7:0] modulus;
    logic [7:0] r2;
    logic [7:0] result;
    logic       busy;
    logic       done;
    logic       error;

    int n_checks = 0;
    int n_fails  = 0;
    int lat;
    int bcnt;

    always #5 clk = ~clk;

    rsa_modexp_core #(.WIDTH(8), .EXP_WIDTH(8)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .stop     (stop),
        .plain    (plain),
        .exponent (exponent),
        .modulus  (modulus),
        .r2       (r2),
        .result   (result),
        .busy     (busy),
        .done     (done),
        .error    (error)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_checks++;
        assert (obs === expv) else begin
            n_fails++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
        end
    endtask

    // Pulse start with the given operands, then count cycles until done rises
    // (bounded), also counting cycles in which busy was high.
    task automatic run_job(input logic [7:0] p, input logic [7:0] e,
                           input logic [7:0] n, input logic [7:0] rr,
                           output int lat_o, output int busy_o);
        @(negedge clk);
        plain = p; exponent = e; modulus = n; r2 = rr; start = 1'b1;
        lat_o  = 0;
        busy_o = 0;
        do begin
            @(negedge clk);
            start = 1'b0;
            lat_o++;
            if (busy === 1'b1) busy_o++;
        end while (done !== 1'b1 && lat_o < 400);
    endtask

    initial begin
        rst_n = 1'b0; start = 1'b0; stop = 1'b0;
        plain = '0; exponent = '0; modulus = '0; r2 = '0;
        repeat (3) @(negedge clk);
        check("reset_result", result, 0);
        check("reset_busy",   busy,   0);
        check("reset_done",   done,   0);
        check("reset_error",  error,  0);
        rst_n = 1'b1;

        // 88^7 mod 187 = 11; N_mm = 3+8+3 = 14; busy spans the 140 MM cycles.
        run_job(8'd88, 8'd7, 8'd187, 8'd86, lat, bcnt);
        check("enc_result",  result, 11);
        check("enc_latency", lat,    141);
        check("enc_busy_cy", bcnt,   140);
        check("enc_busy_lo", busy,   0);
        check("enc_error",   error,  0);
        repeat (3) @(negedge clk);
        check("enc_done_sticky", done, 1);

        // 11^23 mod 187 = 88; N_mm = 3+8+4 = 15.
        run_job(8'd11, 8'd23, 8'd187, 8'd86, lat, bcnt);
        check("dec_result",  result, 88);
        check("dec_latency", lat,    151);

        // Exponent 0 gives 1; N_mm = 11.
        run_job(8'd88, 8'd0, 8'd187, 8'd86, lat, bcnt);
        check("e0_result",  result, 1);
        check("e0_latency", lat,    111);

        // 88^255 mod 187 = 176 (0 mod 11, 6 mod 17); N_mm = 19.
        run_job(8'd88, 8'd255, 8'd187, 8'd86, lat, bcnt);
        check("e255_result",  result, 176);
        check("e255_latency", lat,    191);

        // Even modulus is rejected in one cycle without going busy.
        @(negedge clk);
        plain = 8'd88; exponent = 8'd7; modulus = 8'd100; r2 = 8'd86; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check("even_done",   done,   1);
        check("even_error",  error,  1);
        check("even_result", result, 0);
        check("even_busy",   busy,   0);
        @(negedge clk);
        check("even_busy_after", busy, 0);

        run_job(8'd88, 8'd7, 8'd187, 8'd86, lat, bcnt);
        check("recover_result", result, 11);
        check("recover_error",  error,  0);

        // Abort at cycle 40 of a running job.
        @(negedge clk);
        plain = 8'd88; exponent = 8'd7; modulus = 8'd187; r2 = 8'd86; start = 1'b1;
        repeat (39) begin
            @(negedge clk);
            start = 1'b0;
        end
        check("stop_busy_before", busy, 1);
        stop = 1'b1;
        @(negedge clk);
        stop = 1'b0;
        check("stop_busy",   busy,   0);
        check("stop_done",   done,   0);
        check("stop_result", result, 11);
        repeat (200) @(negedge clk);
        check("stop_quiet_busy",   busy,   0);
        check("stop_quiet_done",   done,   0);
        check("stop_quiet_result", result, 11);

        // start and stop together in IDLE: nothing starts.
        start = 1'b1; stop = 1'b1;
        @(negedge clk);
        start = 1'b0; stop = 1'b0;
        check("startstop_busy", busy, 0);
        repeat (160) @(negedge clk);
        check("startstop_done", done, 0);

        run_job(8'd88, 8'd7, 8'd187, 8'd86, lat, bcnt);
        check("fresh_result",  result, 11);
        check("fresh_latency", lat,    141);

        // Second start at cycle 20 plus operand changes must not disturb the job.
        @(negedge clk);
        plain = 8'd88; exponent = 8'd7; modulus = 8'd187; r2 = 8'd86; start = 1'b1;
        lat = 0;
        do begin
            @(negedge clk);
            lat++;
            start = (lat == 20);
            if (lat == 20) begin
                plain    = 8'd5;
                exponent = 8'd0;
            end
        end while (done !== 1'b1 && lat < 400);
        check("ignore_result",  result, 11);
        check("ignore_latency", lat,    141);
        check("ignore_error",   error,  0);

        // Synchronous reset in the middle of a job.
        @(negedge clk);
        plain = 8'd11; exponent = 8'd23; modulus = 8'd187; r2 = 8'd86; start = 1'b1;
        repeat (30) begin
            @(negedge clk);
            start = 1'b0;
        end
        check("rst_busy_before", busy, 1);
        rst_n = 1'b0;
        @(negedge clk);
        check("rst_result", result, 0);
        check("rst_busy",   busy,   0);
        check("rst_done",   done,   0);
        check("rst_error",  error,  0);
        rst_n = 1'b1;

        run_job(8'd88, 8'd7, 8'd187, 8'd86, lat, bcnt);
        check("post_rst_result",  result, 11);
        check("post_rst_latency", lat,    141);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "watchdog expired");
    end

endmodule
